mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's data/instruction memory interface; it is the target end of the CPU's address/write/data path.
- Accepts one request at a time over a valid/ready handshake.
- Services the request from an internal word-organised RAM after a programmable number of wait states.
- Returns read data, write completion or an error flag through a one-cycle response pulse.

Parameters:
- ADDR_W, 8, byte-address width decoded; the RAM spans 2^ADDR_W bytes (default 256 bytes = 64 words, which includes the exception-vector bytes 252..255).
- WAIT_STATES, 1, number of idle cycles between request acceptance and the response (0..15).

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data, big-endian (bits 31:24 = byte at addr+0).
- req_ready  output  1  responder can accept a request this cycle.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  read data; valid when rsp_valid && !req was write.
- rsp_err  output  1  request rejected (misaligned or out of range); qualified by rsp_valid.
- busy  output  1  transaction in flight (state != IDLE).

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, wait counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. RAM contents are not cleared.
- Reset asserted mid-transaction: the transaction is aborted. A pending write that has not reached its commit edge is not performed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_wr, req_addr and req_wdata into internal registers.
  - Go to WAIT if WAIT_STATES>0, else go directly to RESP.
  - Inputs are ignored in every other state.
- WAIT:
  - The counter loads WAIT_STATES-1 on acceptance and decrements each cycle.
  - At 0, go to RESP.
- Commit edge: the clock edge entering RESP.
  - Read: the RAM word is sampled into rsp_rdata.
  - Write: the RAM word is updated.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - req_ready=0 in RESP, so back-to-back requests are spaced WAIT_STATES+2 cycles apart.
- Latency: rsp_valid is high in cycle N+WAIT_STATES+1, where N is the acceptance cycle.
- Addressing:
  - Word index = latched addr[ADDR_W-1:2].
  - Error when latched addr[1:0]!=0 (misaligned), or when any bit addr[31:ADDR_W] is 1 (out of range).
- On error:
  - rsp_err=1.
  - No RAM write.
  - rsp_rdata holds its previous value.
- rsp_err=0 whenever rsp_valid=0.
- rsp_rdata holds its last read value between responses and is unchanged by write responses.
- Address wrap-around does not occur: addresses beyond the range are errors, never aliased.
- Read of a never-written word returns X in simulation. Benches must initialise the RAM first.

Optional Feature:
- Macro: MEM_RESP_BYTE_EN.
- When defined:
  - Adds input port req_be[3:0], latched at acceptance.
  - A write updates only the enabled byte lanes: be[3] for bits 31:24, be[2] for bits 23:16, be[1] for bits 15:8, be[0] for bits 7:0.
  - Alignment rule: be=4'b0000 on a write is an error. Reads ignore req_be.
  - This lets sb/sh commit without a read-modify-write in the CPU.
- When undefined:
  - No req_be port.
  - Every write updates the full 32-bit word.

Test Plan:
- Reset then idle: hold reset low 3 cycles, release -> req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0x00000000.
- Write then read, WAIT_STATES=1:
  - Write 0xDEADBEEF to addr 0x10 -> rsp_valid exactly 2 cycles after acceptance, rsp_err=0.
  - Read 0x10 -> rsp_rdata=0xDEADBEEF.
- Misaligned and out of range:
  - Write to 0x13 -> rsp_err=1, and a following read of 0x10 still returns 0xDEADBEEF.
  - Read 0x100 with ADDR_W=8 -> rsp_err=1, rsp_rdata unchanged.
- Vector region:
  - Write 0x0000A0B0 to 0xFC, then read 0xFC -> 0x0000A0B0, rsp_err=0.
- Back-to-back with WAIT_STATES=0:
  - req_valid held high with 3 reads -> each accepted every 2nd cycle, req_ready low during RESP, 3 rsp_valid pulses in order.
- Abort:
  - Write 0x11111111 to 0x20 while 0x20 holds 0x55555555.
  - Pull reset low during WAIT -> rsp_valid never pulses.
  - Read 0x20 after release -> 0x55555555.
- With MEM_RESP_BYTE_EN: word 0x20 holds 0x55555555; write 0xAABBCCDD with be=4'b1000 -> read 0x20 returns 0xAA555555.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: single-outstanding request, word RAM, programmable wait states.
// Optional byte-lane write enables when MEM_RESP_BYTE_EN is defined.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef MEM_RESP_BYTE_EN
    input  logic [3:0]  req_be,
`endif
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         WORDS     = 1 << (ADDR_W - 2);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        lat_wr;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
`ifdef MEM_RESP_BYTE_EN
    logic [3:0]  lat_be;
`endif

    logic [31:0] mem [WORDS];

    logic              commit;
    logic              op_wr;
    logic [31:0]       op_addr;
    logic [31:0]       op_wdata;
    logic [3:0]        op_be;
    logic              op_err;
    logic [ADDR_W-3:0] word_idx;

    // With zero wait states the commit happens on the acceptance edge itself,
    // so the operation is taken straight from the request inputs in IDLE.
    always_comb begin
        op_wr    = (state == ST_IDLE) ? req_wr    : lat_wr;
        op_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
        op_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;
`ifdef MEM_RESP_BYTE_EN
        op_be    = (state == ST_IDLE) ? req_be    : lat_be;
`else
        op_be    = 4'hF;
`endif
        commit   = ((state == ST_WAIT) && (wait_cnt == 4'd0)) ||
                   ((state == ST_IDLE) && req_valid && (WAIT_STATES == 0));
        op_err   = (op_addr[1:0] != 2'b00) ||
                   ((op_addr >> ADDR_W) != 32'd0) ||
                   (op_wr && (op_be == 4'b0000));
        word_idx = op_addr[ADDR_W-1:2];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            lat_wr    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
`ifdef MEM_RESP_BYTE_EN
            lat_be    <= 4'd0;
`endif
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_wr    <= req_wr;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
`ifdef MEM_RESP_BYTE_EN
                        lat_be    <= req_be;
`endif
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase

            // Rejected requests leave rsp_rdata holding the previous read.
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= op_err;
                if (!op_err && !op_wr) begin
                    rsp_rdata <= mem[word_idx];
                end
            end
        end
    end

    // RAM is deliberately not reset; an aborted write never reaches commit.
    always_ff @(posedge clock) begin
        if (reset && commit && op_wr && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (op_be[b]) begin
                    mem[word_idx][8*b +: 8] <= op_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with one wait state, one with zero wait states.
// Byte-enable checks are compiled in when MEM_RESP_BYTE_EN is defined.
module tb_mem_responder;

    logic        clock;
    logic        reset1;
    logic        reset0;
    logic        req_valid1;
    logic        req_valid0;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        rdy1, rv1, re1, bz1;
    logic [31:0] rd1;
    logic        rdy0, rv0, re0, bz0;
    logic [31:0] rd0;

    int checks;
    int errors;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[16];

    mem_responder #(.ADDR_W(8), .WAIT_STATES(1)) dut (
        .clock     (clock),
        .reset     (reset1),
        .req_valid (req_valid1),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef MEM_RESP_BYTE_EN
        .req_be    (req_be),
`endif
        .req_ready (rdy1),
        .rsp_valid (rv1),
        .rsp_rdata (rd1),
        .rsp_err   (re1),
        .busy      (bz1)
    );

    mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
        .clock     (clock),
        .reset     (reset0),
        .req_valid (req_valid0),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef MEM_RESP_BYTE_EN
        .req_be    (req_be),
`endif
        .req_ready (rdy0),
        .rsp_valid (rv0),
        .rsp_rdata (rd0),
        .rsp_err   (re0),
        .busy      (bz0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request to the selected instance and waits (bounded) for its response.
    task automatic applyStimulus(input bit sel, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 output logic err, output logic [31:0] rdata, output int lat);
        @(negedge clock);
        checkOutput("ready_before_req", sel ? 32'(rdy0) : 32'(rdy1), 32'd1);
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        if (sel) req_valid0 = 1'b1;
        else     req_valid1 = 1'b1;
        @(posedge clock);
        #1;
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        lat   = -1;
        err   = 1'bx;
        rdata = 32'hx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (sel ? rv0 : rv1) begin
                lat   = c;
                err   = sel ? re0 : re1;
                rdata = sel ? rd0 : rd1;
                break;
            end
        end
    endtask

    initial begin
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] b2b_addr[3];
        logic [31:0] b2b_exp[3];
        int          acc_cyc[3];
        int          idx;
        int          nrsp;
        bit          acc_pending;
        bit          seen;

        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0013, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 32'h0000_00FC, 32'h0000_A0B0, 1'b0, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'h0000_A0B0};
        vecs[7]  = '{1'b1, 32'h0000_0020, 32'h5555_5555, 1'b0, 32'h0000_A0B0};
        vecs[8]  = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h5555_5555};
        vecs[9]  = '{1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0, 32'h5555_5555};
        vecs[10] = '{1'b1, 32'h0000_0008, 32'hCAFE_F00D, 1'b0, 32'h5555_5555};
        vecs[11] = '{1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h1234_5678};
        vecs[12] = '{1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[13] = '{1'b1, 32'h8000_0010, 32'h9999_9999, 1'b1, 32'hCAFE_F00D};
        vecs[14] = '{1'b0, 32'h0000_0002, 32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[15] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};

        req_valid1 = 1'b0;
        req_valid0 = 1'b0;
        req_wr     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_be     = 4'hF;
        reset1     = 1'b0;
        reset0     = 1'b0;
        repeat (3) @(negedge clock);
        reset1 = 1'b1;
        reset0 = 1'b1;
        @(negedge clock);
        checkOutput("reset_ready", 32'(rdy1), 32'd1);
        checkOutput("reset_busy",  32'(bz1),  32'd0);
        checkOutput("reset_valid", 32'(rv1),  32'd0);
        checkOutput("reset_rdata", rd1,       32'h0);
        checkOutput("reset_err",   32'(re1),  32'd0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF, err, rdata, lat);
            $display("[TB] vec %0d wr=%0b addr=%h", i, vecs[i].wr, vecs[i].addr);
            checkOutput("latency", 32'(lat), 32'd2);
            checkOutput("rsp_err", 32'(err), 32'(vecs[i].exp_err));
            checkOutput("rsp_rdata", rdata, vecs[i].exp_rdata);
            @(negedge clock);
            checkOutput("pulse_end_valid", 32'(rv1), 32'd0);
            checkOutput("pulse_end_err",   32'(re1), 32'd0);
        end

        // Abort a write to 0x20 by pulling reset during WAIT.
        @(negedge clock);
        req_wr     = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'h1111_1111;
        req_valid1 = 1'b1;
        @(posedge clock);
        #1;
        req_valid1 = 1'b0;
        @(negedge clock);
        checkOutput("abort_busy_in_wait", 32'(bz1), 32'd1);
        reset1 = 1'b0;
        seen   = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (rv1) seen = 1'b1;
            @(negedge clock);
            if (rv1) seen = 1'b1;
        end
        reset1 = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (rv1) seen = 1'b1;
        end
        checkOutput("abort_no_rsp",  32'(seen), 32'd0);
        checkOutput("abort_ready",   32'(rdy1), 32'd1);
        checkOutput("abort_busy",    32'(bz1),  32'd0);
        checkOutput("abort_rdata",   rd1,       32'h0);
        applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, err, rdata, lat);
        checkOutput("abort_read_err",   32'(err), 32'd0);
        checkOutput("abort_read_rdata", rdata,    32'h5555_5555);

        // Zero-wait-state instance: preload, then three back-to-back reads.
        b2b_addr = '{32'h0, 32'h4, 32'h8};
        b2b_exp  = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, b2b_addr[i], b2b_exp[i], 4'hF, err, rdata, lat);
            checkOutput("ws0_write_latency", 32'(lat), 32'd1);
            checkOutput("ws0_write_err",     32'(err), 32'd0);
        end
        @(negedge clock);
        req_wr      = 1'b0;
        idx         = 0;
        nrsp        = 0;
        acc_pending = 1'b0;
        acc_cyc     = '{-1, -1, -1};
        req_addr    = b2b_addr[0];
        req_valid0  = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc > 0) @(negedge clock);
            if (acc_pending) begin
                acc_pending = 1'b0;
                idx++;
                if (idx < 3) req_addr = b2b_addr[idx];
                else         req_valid0 = 1'b0;
            end
            if (rv0) begin
                checkOutput("b2b_ready_low_in_resp", 32'(rdy0), 32'd0);
                if (nrsp < 3) checkOutput("b2b_rdata", rd0, b2b_exp[nrsp]);
                nrsp++;
            end
            if (req_valid0 && rdy0) begin
                acc_cyc[idx] = cyc;
                acc_pending  = 1'b1;
            end
        end
        req_valid0 = 1'b0;
        checkOutput("b2b_rsp_count", 32'(nrsp), 32'd3);
        checkOutput("b2b_spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
        checkOutput("b2b_spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);

`ifdef MEM_RESP_BYTE_EN
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h5555_5555, 4'hF, err, rdata, lat);
        checkOutput("be_full_err", 32'(err), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b1000, err, rdata, lat);
        checkOutput("be_lane_err", 32'(err), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, err, rdata, lat);
        checkOutput("be_zero_err", 32'(err), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 4'b0000, err, rdata, lat);
        checkOutput("be_read_err",   32'(err), 32'd0);
        checkOutput("be_read_rdata", rdata,    32'hAA55_5555);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
